// File: rtl/sound_request_arbiter.sv
// sound_request_arbiter
// Shares one speaker pin between NUM_SOURCES tune players. One-cycle play
// requests are latched into a pending set. The lowest pending index (the
// highest priority) is granted the speaker. Its player is started with an
// active-low trigger pulse, and its square wave is routed to the pin until
// the player drops busy. A watchdog limits the play length, and a silent gap
// separates consecutive tunes.
//
// Optional feature macro: SOUND_PREEMPT_EN
//   When defined, a pending request at a higher priority than the current
//   owner aborts the current play during ACK/PLAY. The aborted player gets a
//   reset pulse, and the arbiter returns straight to IDLE with no gap.
//
// Player handshake: source_trigger[g] is low for exactly the one START cycle.
// The player then has ACK_CYCLES cycles to raise source_busy[g]. The play
// lasts while source_busy[g] stays high. source_reset[g] is a one-cycle
// active-low abort that is issued only by this block.
module sound_request_arbiter #(
    parameter int NUM_SOURCES     = 4,
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int MAX_PLAY_MS     = 8000,
    parameter int GAP_MS          = 50,
    parameter int ACK_CYCLES      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SOURCES-1:0] request,
    input  logic [NUM_SOURCES-1:0] source_sound,
    input  logic [NUM_SOURCES-1:0] source_busy,
    output logic [NUM_SOURCES-1:0] source_trigger,
    output logic [NUM_SOURCES-1:0] source_reset,
    output logic [NUM_SOURCES-1:0] grant,
    output logic                   sound,
    output logic                   busy,
    output logic                   timeout_pulse,
    output logic [2:0]             stateDebug
);

    localparam int unsigned MS_TICKS   = int'(CLOCK_FREQUENCY / 1000);
    localparam int unsigned PLAY_RAW   = int'(MAX_PLAY_MS) * MS_TICKS;
    localparam int unsigned GAP_RAW    = int'(GAP_MS) * MS_TICKS;
    localparam int unsigned PLAY_LIMIT = (PLAY_RAW < 1) ? 1 : PLAY_RAW;
    localparam int unsigned GAP_LIMIT  = (GAP_RAW < 1) ? 1 : GAP_RAW;
    localparam int unsigned ACK_LIMIT  = (ACK_CYCLES < 1) ? 1 : ACK_CYCLES;

    // Terminal counts: each waiting state lasts exactly LIMIT cycles.
    localparam logic [31:0] PLAY_LAST = 32'(PLAY_LIMIT - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_LIMIT - 1);
    localparam logic [31:0] ACK_LAST  = 32'(ACK_LIMIT - 1);

    localparam logic [NUM_SOURCES-1:0] ONE = NUM_SOURCES'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ACK   = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } stateType;

    stateType               state;
    stateType               nextState;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] nextGrant;
    logic [NUM_SOURCES-1:0] clearMask;
    logic [NUM_SOURCES-1:0] lowestPending;
    logic [31:0]            count;
    logic [31:0]            countNext;
    logic                   abortPlay;
    logic                   timeoutHit;
    logic                   ownerBusy;
    logic                   playing;

    // Isolate the lowest set bit of pending.
    assign lowestPending = pending & (~pending + ONE);
    assign ownerBusy     = |(source_busy & grant);
    assign playing       = (state == ACK) || (state == PLAY);

    assign source_trigger = (state == START) ? ~grant : '1;
    assign busy           = (state != IDLE);
    assign stateDebug     = state;

    // Next-state, grant and counter decisions for the arbitration FSM.
    always_comb begin
        nextState  = state;
        nextGrant  = grant;
        countNext  = count + 32'd1;
        clearMask  = '0;
        abortPlay  = 1'b0;
        timeoutHit = 1'b0;

        if (!enable) begin
            // Muting overrides everything. A started player is told to stop.
            nextState = IDLE;
            nextGrant = '0;
            countNext = '0;
            abortPlay = (state == START) || playing;
        end else begin
            case (state)
                IDLE: begin
                    countNext = '0;
                    if (pending != '0) begin
                        nextState = START;
                        nextGrant = lowestPending;
                        clearMask = lowestPending;
                    end
                end

                START: begin
                    countNext = '0;
                    nextState = ACK;
                end

                ACK: begin
`ifdef SOUND_PREEMPT_EN
                    if ((pending & (grant - ONE)) != '0) begin
                        abortPlay = 1'b1;
                        nextState = IDLE;
                        nextGrant = '0;
                        countNext = '0;
                    end else
`endif
                    if (ownerBusy) begin
                        nextState = PLAY;
                        countNext = '0;
                    end else if (count == ACK_LAST) begin
                        abortPlay  = 1'b1;
                        timeoutHit = 1'b1;
                        nextState  = GAP;
                        nextGrant  = '0;
                        countNext  = '0;
                    end
                end

                PLAY: begin
`ifdef SOUND_PREEMPT_EN
                    if ((pending & (grant - ONE)) != '0) begin
                        abortPlay = 1'b1;
                        nextState = IDLE;
                        nextGrant = '0;
                        countNext = '0;
                    end else
`endif
                    if (!ownerBusy) begin
                        nextState = GAP;
                        nextGrant = '0;
                        countNext = '0;
                    end else if (count == PLAY_LAST) begin
                        abortPlay  = 1'b1;
                        timeoutHit = 1'b1;
                        nextState  = GAP;
                        nextGrant  = '0;
                        countNext  = '0;
                    end
                end

                GAP: begin
                    nextGrant = '0;
                    if (count == GAP_LAST) begin
                        nextState = IDLE;
                        countNext = '0;
                    end
                end

                default: begin
                    nextState = IDLE;
                    nextGrant = '0;
                    countNext = '0;
                end
            endcase
        end
    end

    // FSM state, owner and shared counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
        end else begin
            state <= nextState;
            grant <= nextGrant;
            count <= countNext;
        end
    end

    // Pending requests. A request in the same cycle as the grant keeps the bit set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clearMask) | request;
        end
    end

    // Speaker pin, registered from the owner's square wave while it may play.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sound <= 1'b0;
        end else begin
            sound <= (enable && playing) ? |(source_sound & grant) : 1'b0;
        end
    end

    // One-cycle abort and timeout pulses, aligned with the cycle the FSM leaves the play.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            source_reset  <= '1;
            timeout_pulse <= 1'b0;
        end else begin
            source_reset  <= abortPlay ? ~grant : '1;
            timeout_pulse <= timeoutHit;
        end
    end

endmodule

// File: tb/tb_sound_request_arbiter.sv
// Self-checking bench for sound_request_arbiter. It uses 1 ms = 1 cycle,
// MAX_PLAY_MS=20, GAP_MS=3 and ACK_CYCLES=4. The expected grant order is
// queued when requests are driven, and it is popped on each trigger pulse.
module tb_sound_request_arbiter;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] request = '0;
    logic [N-1:0] source_sound = '0;
    logic [N-1:0] source_busy = '0;
    logic [N-1:0] source_trigger;
    logic [N-1:0] source_reset;
    logic [N-1:0] grant;
    logic         sound;
    logic         busy;
    logic         timeout_pulse;
    logic [2:0]   stateDebug;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    sound_request_arbiter #(
        .NUM_SOURCES(N),
        .CLOCK_FREQUENCY(1000),
        .MAX_PLAY_MS(20),
        .GAP_MS(3),
        .ACK_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .request(request),
        .source_sound(source_sound),
        .source_busy(source_busy),
        .source_trigger(source_trigger),
        .source_reset(source_reset),
        .grant(grant),
        .sound(sound),
        .busy(busy),
        .timeout_pulse(timeout_pulse),
        .stateDebug(stateDebug)
    );

    // Clock generation.
    always #5 clock = ~clock;

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Queue the expected grants in priority order.
    task automatic push_mask(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) exp_q.push_back(2'(i));
        end
    endtask

    // Drive a one-cycle request pulse and record the expected grants.
    task automatic pulse_request(input logic [N-1:0] mask);
        request = mask;
        push_mask(mask);
        tick();
        request = '0;
    endtask

    // Wait for a trigger pulse, and check it against the scoreboard head.
    task automatic wait_trigger(output int idx, output int waited);
        int n;
        logic [N-1:0] expOneHot;
        n = 0;
        idx = 0;
        waited = 0;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty no expected grant queued");
        end else begin
            idx = int'(exp_q.pop_front());
            expOneHot = N'(1) << idx;
            do begin
                tick();
                n++;
            end while (source_trigger === '1 && n < 40);
            waited = n;
            if (source_trigger === '1) begin
                failures++;
                $display("FAIL trigger_timeout no trigger within %0d cycles, expected source %0d", n, idx);
            end else begin
                if (source_trigger !== ~expOneHot || grant !== expOneHot) begin
                    failures++;
                    $display("FAIL trigger_grant trigger=%b grant=%b expected trigger=%b grant=%b",
                             source_trigger, grant, ~expOneHot, expOneHot);
                end
            end
        end
    endtask

    // The trigger must be exactly one cycle wide.
    task automatic ack_cycle();
        tick();
        checks++;
        if (source_trigger !== '1) begin
            failures++;
            $display("FAIL trigger_width trigger=%b expected %b", source_trigger, 4'b1111);
        end
    endtask

    // Player idx plays len cycles with random sound. Optional mid-play request.
    task automatic play_tune(input int idx, input int len, input logic [N-1:0] midReq);
        logic last;
        source_busy[idx] = 1'b1;
        last = 1'($urandom_range(0, 1));
        source_sound[idx] = last;
        for (int k = 0; k < len; k++) begin
            if (k == 1 && midReq != '0) begin
                request = midReq;
                push_mask(midReq);
            end
            if (k == 2) request = '0;
            tick();
            checks++;
            if (sound !== last) begin
                failures++;
                $display("FAIL sound_follow src=%0d cycle=%0d sound=%b expected %b", idx, k, sound, last);
            end
            if (k == 0) begin
                checks++;
                if (grant !== (N'(1) << idx)) begin
                    failures++;
                    $display("FAIL play_grant grant=%b expected %b", grant, N'(1) << idx);
                end
            end
            last = 1'($urandom_range(0, 1));
            source_sound[idx] = last;
        end
        source_busy[idx] = 1'b0;
        tick();
        checks++;
        if (sound !== last || grant !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL gap_entry sound=%b grant=%b busy=%b expected sound=%b grant=0000 busy=1",
                     sound, grant, busy, last);
        end
        source_sound[idx] = 1'b0;
    endtask

    // Count silent gap cycles until busy drops. startCount cycles are already seen.
    task automatic check_gap(input int startCount);
        int n;
        bit done;
        n = startCount;
        done = 1'b0;
        while (!done && n < 20) begin
            tick();
            if (busy === 1'b1) begin
                n++;
                checks++;
                if (sound !== 1'b0 || grant !== '0) begin
                    failures++;
                    $display("FAIL gap_silent sound=%b grant=%b expected 0 and 0000", sound, grant);
                end
            end else begin
                done = 1'b1;
            end
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL gap_length got %0d cycles expected 3", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (grant !== '0 || sound !== 1'b0 || busy !== 1'b0 || timeout_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs grant=%b sound=%b busy=%b timeout=%b expected 0", grant, sound, busy, timeout_pulse);
        end
        checks++;
        if (source_trigger !== '1 || source_reset !== '1) begin
            failures++;
            $display("FAIL reset_pulses trigger=%b reset=%b expected 1111", source_trigger, source_reset);
        end
        checks++;
        if (stateDebug !== 3'd0) begin
            failures++;
            $display("FAIL reset_state state=%0d expected 0", stateDebug);
        end
        reset = 1'b1;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int idx, w;
        pulse_request(4'b0100);
        wait_trigger(idx, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL single_latency got %0d expected 1", w);
        end
        ack_cycle();
        play_tune(idx, $urandom_range(6, 12), '0);
        check_gap(1);
    endtask

    task automatic test_priority();
        int idx, w;
        pulse_request(4'b1010);
        wait_trigger(idx, w);
        ack_cycle();
        play_tune(idx, $urandom_range(4, 8), '0);
        check_gap(1);
        wait_trigger(idx, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL priority_second_latency got %0d expected 1", w);
        end
        ack_cycle();
        play_tune(idx, $urandom_range(4, 8), '0);
        check_gap(1);
    endtask

    task automatic test_watchdog();
        int idx, w, n;
        pulse_request(4'b0001);
        wait_trigger(idx, w);
        ack_cycle();
        source_busy[0] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (timeout_pulse !== 1'b1 && n < 40);
        checks++;
        if (n != 21) begin
            failures++;
            $display("FAIL watchdog_time got %0d cycles expected 21", n);
        end
        checks++;
        if (source_reset !== 4'b1110 || grant !== '0) begin
            failures++;
            $display("FAIL watchdog_abort reset=%b grant=%b expected 1110 0000", source_reset, grant);
        end
        tick();
        checks++;
        if (timeout_pulse !== 1'b0 || source_reset !== '1) begin
            failures++;
            $display("FAIL watchdog_pulse_width timeout=%b reset=%b expected 0 1111", timeout_pulse, source_reset);
        end
        source_busy[0] = 1'b0;
        check_gap(2);
    endtask

    task automatic test_ack_timeout();
        int idx, w, n;
        bit restarted;
        pulse_request(4'b0010);
        wait_trigger(idx, w);
        n = 0;
        do begin
            tick();
            n++;
        end while (timeout_pulse !== 1'b1 && n < 20);
        checks++;
        if (n != 5 || source_reset !== 4'b1101) begin
            failures++;
            $display("FAIL ack_timeout cycles=%0d reset=%b expected 5 1101", n, source_reset);
        end
        check_gap(1);
        restarted = 1'b0;
        repeat (6) begin
            tick();
            if (busy !== 1'b0 || source_trigger !== '1) restarted = 1'b1;
        end
        checks++;
        if (restarted) begin
            failures++;
            $display("FAIL ack_pending_cleared restarted=1 expected 0");
        end
    endtask

    task automatic test_enable_drop();
        int idx, w;
        pulse_request(4'b0001);
        wait_trigger(idx, w);
        ack_cycle();
        source_busy[0] = 1'b1;
        source_sound[0] = 1'b1;
        repeat (3) tick();
        pulse_request(4'b1000);
        enable = 1'b0;
        tick();
        checks++;
        if (sound !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_mute sound=%b grant=%b busy=%b expected 0 0000 0", sound, grant, busy);
        end
        checks++;
        if (source_reset !== 4'b1110 || timeout_pulse !== 1'b0) begin
            failures++;
            $display("FAIL enable_abort reset=%b timeout=%b expected 1110 0", source_reset, timeout_pulse);
        end
        source_busy[0] = 1'b0;
        source_sound[0] = 1'b0;
        tick();
        checks++;
        if (source_reset !== '1) begin
            failures++;
            $display("FAIL enable_abort_width reset=%b expected 1111", source_reset);
        end
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_hold busy=%b expected 0", busy);
        end
        enable = 1'b1;
        wait_trigger(idx, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL enable_resume_latency got %0d expected 1", w);
        end
        ack_cycle();
        play_tune(idx, 5, '0);
        check_gap(1);
    endtask

    task automatic test_rearm();
        int idx, w;
        pulse_request(4'b0100);
        wait_trigger(idx, w);
        ack_cycle();
        play_tune(idx, 8, 4'b0100);
        check_gap(1);
        wait_trigger(idx, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL rearm_latency got %0d expected 1", w);
        end
        ack_cycle();
        play_tune(idx, 4, '0);
        check_gap(1);
    endtask

    task automatic test_preempt();
        int idx, w;
        pulse_request(4'b0100);
        wait_trigger(idx, w);
        ack_cycle();
`ifdef SOUND_PREEMPT_EN
        source_busy[2] = 1'b1;
        tick();
        tick();
        pulse_request(4'b0001);
        tick();
        checks++;
        if (source_reset !== 4'b1011 || timeout_pulse !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
            failures++;
            $display("FAIL preempt_abort reset=%b timeout=%b busy=%b grant=%b expected 1011 0 0 0000",
                     source_reset, timeout_pulse, busy, grant);
        end
        source_busy[2] = 1'b0;
        wait_trigger(idx, w);
`else
        play_tune(idx, 8, 4'b0001);
        check_gap(1);
        wait_trigger(idx, w);
`endif
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL preempt_next_latency got %0d expected 1", w);
        end
        ack_cycle();
        play_tune(idx, 4, '0);
        check_gap(1);
    endtask

    task automatic test_async_reset();
        int idx, w;
        bit restarted;
        pulse_request(4'b1000);
        wait_trigger(idx, w);
        ack_cycle();
        source_busy[3] = 1'b1;
        source_sound[3] = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== '0 || sound !== 1'b0) begin
            failures++;
            $display("FAIL async_reset busy=%b grant=%b sound=%b expected 0 0000 0", busy, grant, sound);
        end
        checks++;
        if (source_reset !== '1 || source_trigger !== '1) begin
            failures++;
            $display("FAIL async_reset_pulses reset=%b trigger=%b expected 1111 1111", source_reset, source_trigger);
        end
        source_busy[3] = 1'b0;
        source_sound[3] = 1'b0;
        tick();
        reset = 1'b1;
        restarted = 1'b0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0) restarted = 1'b1;
        end
        checks++;
        if (restarted) begin
            failures++;
            $display("FAIL async_reset_idle restarted=1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_watchdog();
        test_ack_timeout();
        test_enable_drop();
        test_rearm();
        test_preempt();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
